// File: rtl/l1_cache_responder.sv
// l1_cache_responder: direct-mapped, write-back, write-allocate L1 cache that
// answers CPU word requests and moves 128-bit lines to/from physical memory.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   mem_read / mem_write        held CPU request (both high = write)
//   mem_address / mem_wdata     CPU byte address and write word
//   mem_byte_enable             write mask, [1]=high byte, [0]=low byte
//   mem_rdata / mem_resp        read word and one-cycle completion (same cycle on hit)
//   pmem_read / pmem_write      line fill / writeback request, held until pmem_resp
//   pmem_address / pmem_wdata   line address ([3:0]=0) and writeback line
//   pmem_rdata / pmem_resp      fill line and completion pulse
//   hit_count / miss_count      saturating performance counters
//
// Optional feature: define L1_PERF_COUNTERS_EN to build the counters;
// otherwise both counter ports are tied to zero.
module l1_cache_responder #(
  parameter int unsigned IDX_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int unsigned SETS   = 1 << IDX_BITS;
  localparam int unsigned TAG_W  = 12 - IDX_BITS;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_next;

  logic [SETS-1:0]   valid_arr;
  logic [SETS-1:0]   dirty_arr;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [LINE_W-1:0] line_arr [SETS];

  // Line address of the outstanding miss, so a dropped request cannot
  // redirect the transfer or the install.
  logic [11:0]       miss_line;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic [2:0]          req_word;
  logic [IDX_BITS-1:0] miss_idx;
  logic [TAG_W-1:0]    miss_tag;
  logic                req;
  logic                hit;
  logic [WORD_W-1:0]   cur_word;
  logic [WORD_W-1:0]   merged_word;
  logic                hit_wr;
  logic                fill;
  logic                miss_start;
  logic                unused_addr_bit;

  assign req_tag   = mem_address[15 -: TAG_W];
  assign req_idx   = mem_address[3+IDX_BITS:4];
  assign req_word  = mem_address[3:1];
  assign miss_idx  = miss_line[IDX_BITS-1:0];
  assign miss_tag  = miss_line[11:IDX_BITS];
  assign req       = mem_read | mem_write;
  assign hit       = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
  assign cur_word  = line_arr[req_idx][{req_word, 4'b0000} +: WORD_W];
  assign merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : cur_word[15:8],
                        mem_byte_enable[0] ? mem_wdata[7:0]  : cur_word[7:0]};
  // Byte steering is the CPU's job, so address bit 0 is deliberately ignored.
  assign unused_addr_bit = mem_address[0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= CHECK;
    else       state <= state_next;
  end

  // Next state, handshake outputs and array write enables.
  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    hit_wr       = 1'b0;
    fill         = 1'b0;
    miss_start   = 1'b0;
    case (state)
      CHECK: begin
        if (req && !reset) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = cur_word;
            hit_wr    = mem_write;
          end else begin
            miss_start = 1'b1;
            state_next = dirty_arr[req_idx] ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[miss_idx], miss_idx, 4'b0000};
        pmem_wdata   = line_arr[miss_idx];
        if (pmem_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_line, 4'b0000};
        if (pmem_resp) begin
          fill       = !reset;
          state_next = CHECK;
        end
      end
      default: state_next = CHECK;
    endcase
  end

  // Valid/dirty bits; the only per-set state that reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      if (hit_wr) dirty_arr[req_idx] <= 1'b1;
      if (fill) begin
        valid_arr[miss_idx] <= 1'b1;
        dirty_arr[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays and miss address capture; enables already exclude reset.
  always_ff @(posedge clk) begin
    if (miss_start) miss_line <= mem_address[15:4];
    if (hit_wr) line_arr[req_idx][{req_word, 4'b0000} +: WORD_W] <= merged_word;
    if (fill) begin
      line_arr[miss_idx] <= pmem_rdata;
      tag_arr[miss_idx]  <= miss_tag;
    end
  end

`ifdef L1_PERF_COUNTERS_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;
  logic        post_fill;

  // The hit that completes a miss right after the fill is not a real hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q     <= '0;
      miss_q    <= '0;
      post_fill <= 1'b0;
    end else begin
      post_fill <= fill;
      if (mem_resp && !post_fill && (hit_q != 16'hFFFF)) hit_q <= hit_q + 16'd1;
      if (miss_start && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_cache_responder.sv
// Self-checking bench for l1_cache_responder: randomized CPU requests checked
// against a flat word-memory model plus a set-level hit/miss model; a
// behavioural physical memory answers line transfers.
module tb_l1_cache_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address, mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count, miss_count;

  l1_cache_responder #(.IDX_BITS(3)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct { bit is_read; logic [15:0] data; } sb_t;
  typedef struct { bit is_write; logic [15:0] addr; } px_t;

  sb_t          sb_q[$];
  px_t          px_q[$];
  logic [127:0] store   [int];
  logic [15:0]  ref_mem [int];
  int  n_cmp = 0, n_err = 0;
  int  cyc = 0, last_fill_cyc = 0;
  bit  hold_pmem = 0, inject = 0;
  bit  mvalid [8];
  bit  mdirty [8];
  int  mtag   [8];
  int  mhits = 0, mmisses = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] init_word(int waddr);
    logic [31:0] h;
    h = waddr * 32'd40503;
    return h[15:0] ^ h[31:16] ^ 16'h5a5a;
  endfunction

  function automatic logic [127:0] store_line(int laddr);
    logic [127:0] l;
    if (store.exists(laddr)) return store[laddr];
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = init_word(laddr / 2 + i);
    return l;
  endfunction

  // What the CPU must observe at a word address.
  function automatic logic [15:0] ref_word(int waddr);
    logic [127:0] l;
    if (ref_mem.exists(waddr)) return ref_mem[waddr];
    l = store_line((waddr / 8) * 16);
    return l[(waddr % 8) * 16 +: 16];
  endfunction

  function automatic logic [127:0] ref_line(int laddr);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = ref_word(laddr / 2 + i);
    return l;
  endfunction

  // Reset loses every cached line, including dirty data never written back.
  function automatic void clear_model();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    ref_mem.delete();
    px_q.delete();
    sb_q.delete();
    mhits   = 0;
    mmisses = 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Physical memory: checks each transfer's kind/address when it starts,
  // answers after a random delay.
  initial begin
    bit          in_txn;
    bit          cur_wr;
    logic [15:0] cur_addr;
    int          wait_cnt;
    px_t         p;
    in_txn     = 0;
    cur_wr     = 0;
    cur_addr   = '0;
    wait_cnt   = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (inject) begin
        inject     = 0;
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else if (reset || !(pmem_read || pmem_write)) begin
        in_txn = 0;
      end else if (!in_txn) begin
        in_txn   = 1;
        wait_cnt = $urandom_range(0, 3);
        cur_wr   = pmem_write;
        cur_addr = pmem_address;
        chk("pmem_align", 128'(pmem_address[3:0]), 128'(0));
        if (px_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pmem_unexpected: got transfer wr=%0d addr 0x%h, expected none", pmem_write, pmem_address);
        end else begin
          p = px_q.pop_front();
          chk("pmem_kind", 128'(pmem_write), 128'(p.is_write));
          chk("pmem_addr", 128'(pmem_address), 128'(p.addr));
        end
      end else if (!hold_pmem) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          if (cur_wr) begin
            chk("wb_line", pmem_wdata, ref_line(int'(cur_addr)));
            store[int'(cur_addr)] = pmem_wdata;
          end else begin
            pmem_rdata    = store_line(int'(cur_addr));
            last_fill_cyc = cyc;
          end
          pmem_resp = 1'b1;
          in_txn    = 0;
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial forever begin
    sb_t e;
    @(negedge clk);
    chk("pmem_excl", 128'(pmem_read & pmem_write), 128'(0));
    chk("resp_in_xfer", 128'(mem_resp & (pmem_read | pmem_write)), 128'(0));
    if (mem_resp) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: got mem_resp with rdata 0x%h, expected none", mem_rdata);
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) chk("rdata", 128'(mem_rdata), 128'(e.data));
      end
    end else begin
      chk("rdata_idle", 128'(mem_rdata), 128'(0));
    end
  end

  task automatic do_req(input logic [15:0] addr, input bit rd, input bit wr,
                        input logic [15:0] wd, input logic [1:0] be);
    int          set, tg, waddr, issue, rc;
    bit          hit, got;
    logic [15:0] old;
    sb_t         e;
    px_t         p;
    set   = int'(addr[6:4]);
    tg    = int'(addr[15:7]);
    waddr = int'(addr[15:1]);
    hit   = mvalid[set] && (mtag[set] == tg);
    if (!hit) begin
      if (mvalid[set] && mdirty[set]) begin
        p.is_write = 1;
        p.addr     = 16'((mtag[set] << 7) | (set << 4));
        px_q.push_back(p);
      end
      p.is_write = 0;
      p.addr     = {addr[15:4], 4'h0};
      px_q.push_back(p);
      mvalid[set] = 1;
      mdirty[set] = 0;
      mtag[set]   = tg;
      mmisses++;
    end else begin
      mhits++;
    end
    if (wr) begin
      old            = ref_word(waddr);
      ref_mem[waddr] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
      mdirty[set]    = 1;
      e.is_read      = 0;
      e.data         = ref_mem[waddr];
    end else begin
      e.is_read = 1;
      e.data    = ref_word(waddr);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    mem_address     = addr;
    mem_read        = rd;
    mem_write       = wr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    issue           = cyc;
    got             = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = 1;
        break;
      end
    end
    rc = cyc;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: got no mem_resp for 0x%h, expected one within 200 cycles", addr);
      sb_q.delete();
    end else if (hit) begin
      chk("hit_latency", 128'(rc), 128'(issue));
    end else begin
      chk("miss_latency", 128'(rc), 128'(last_fill_cyc + 1));
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic chk_counters(input int eh, input int em);
`ifdef L1_PERF_COUNTERS_EN
    chk("hit_count", 128'(hit_count), 128'(eh));
    chk("miss_count", 128'(miss_count), 128'(em));
`else
    chk("hit_count", 128'(hit_count), 128'(eh & 0));
    chk("miss_count", 128'(miss_count), 128'(em & 0));
`endif
  endtask

  initial begin
    logic [127:0] lv;
    logic [8:0]   tg;
    logic [2:0]   st, wsel;
    logic [15:0]  a;
    int           op;
    bit           got;
    px_t          p;
    reset           = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk_counters(0, 0);

    // Line 0x1230 holds 0xBEEF at word 2 and 0x1111 at word 3.
    lv = store_line(16'h1230);
    lv[47:32] = 16'hBEEF;
    lv[63:48] = 16'h1111;
    store[16'h1230] = lv;

    do_req(16'h1234, 1, 0, 16'h0, 2'b00);      // cold miss
    do_req(16'h1234, 1, 0, 16'h0, 2'b00);      // hit
    do_req(16'h1236, 0, 1, 16'hAA55, 2'b10);   // high-byte write
    do_req(16'h1236, 1, 0, 16'h0, 2'b00);      // reads 0xAA11
    do_req(16'h1A34, 1, 0, 16'h0, 2'b00);      // conflict: writeback then fill
    do_req(16'h1A34, 1, 1, 16'h0F0F, 2'b11);   // read+write acts as write
    @(negedge clk);
    inject = 1;                                // stray pmem_resp in CHECK
    repeat (3) @(posedge clk);
    do_req(16'h1A34, 1, 0, 16'h0, 2'b00);
    do_req(16'h1236, 1, 0, 16'h0, 2'b00);      // merged word back from memory

    // Reset while a fill is outstanding.
    do_reset();
    hold_pmem = 1;
    p.is_write = 0;
    p.addr     = 16'h3450;
    px_q.push_back(p);
    @(posedge clk);
    #1;
    mem_address = 16'h3456;
    mem_read    = 1'b1;
    got         = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) begin
        got = 1;
        break;
      end
    end
    chk("alloc_started", 128'(got), 128'(1));
    @(posedge clk);
    #1;
    reset    = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_pmem_read", 128'(pmem_read), 128'(0));
    clear_model();
    hold_pmem = 0;
    do_req(16'h3456, 1, 0, 16'h0, 2'b00);      // misses again

    // Counter scenario: 2 misses, 3 hits.
    do_reset();
    do_req(16'h2000, 1, 0, 16'h0, 2'b00);
    do_req(16'h2000, 1, 0, 16'h0, 2'b00);
    do_req(16'h2002, 1, 0, 16'h0, 2'b00);
    do_req(16'h2010, 1, 0, 16'h0, 2'b00);
    do_req(16'h2010, 0, 1, 16'h1234, 2'b01);
    chk_counters(3, 2);

    // Random traffic over a small tag pool to force hits, conflicts and writebacks.
    for (int n = 0; n < 300; n++) begin
      tg   = 9'(9'h040 + $urandom_range(0, 3));
      st   = 3'($urandom_range(0, 7));
      wsel = 3'($urandom_range(0, 7));
      a    = {tg, st, wsel, 1'($urandom_range(0, 1))};
      op   = $urandom_range(0, 2);
      do_req(a, op != 1, op != 0, 16'($urandom()), 2'($urandom()));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    chk_counters(mhits, mmisses);

    repeat (4) @(posedge clk);
    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    chk("pmem_drained", 128'(px_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
